// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input, instruction-memory write port and boot
//               status signals of the instruction-memory loader.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
);
    logic [7:0]             in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   restart;
    logic                   we;
    logic [INS_ADDRESS-1:0] wa;
    logic [INS_W-1:0]       wd;
    logic                   core_rst;
    logic                   done;
    logic                   error;

    // master: byte source / system side; slave: the loader itself
    modport master (
        output in_data, in_valid, restart,
        input  in_ready, we, wa, wd, core_rst, done, error
    );

    modport slave (
        input  in_data, in_valid, restart,
        output in_ready, we, wa, wd, core_rst, done, error
    );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Boot loader that fills instruction memory from a length-
//               prefixed byte stream (little-endian words from word 0) and
//               holds the core in reset until the load completes.
//               Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam int          DEPTH   = 2 ** (INS_ADDRESS - 2);
    localparam int          WIDX_W  = INS_ADDRESS - 2;
    localparam logic [16:0] c_depth = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_HDR0 = 3'd0,
        S_HDR1 = 3'd1,
        S_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK  = 3'd3,
`endif
        S_DONE = 3'd4,
        S_ERR  = 3'd5
    } state_t;

    state_t                 r_state;
    logic [7:0]             r_count_lo;
    logic [15:0]            r_remain;
    logic [WIDX_W-1:0]      r_widx;
    logic [1:0]             r_bcnt;
    logic [23:0]            r_word;
    logic                   r_in_ready;
    logic                   r_we;
    logic [INS_ADDRESS-1:0] r_wa;
    logic [INS_W-1:0]       r_wd;
    logic                   r_core_rst;
    logic                   r_done;
    logic                   r_error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             r_xor;
`endif

    logic                   w_accept;
    logic [15:0]            w_count;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_count  = {bus.in_data, r_count_lo};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_HDR0;
            r_count_lo <= 8'd0;
            r_remain   <= 16'd0;
            r_widx     <= '0;
            r_bcnt     <= 2'd0;
            r_word     <= 24'd0;
            r_in_ready <= 1'b1;
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_HDR0: begin
                    if (w_accept) begin
                        r_count_lo <= bus.in_data;
                        r_state    <= S_HDR1;
                    end
                end

                S_HDR1: begin
                    if (w_accept) begin
                        r_remain <= w_count;
                        if ({1'b0, w_count} > c_depth) begin
                            r_state    <= S_ERR;
                            r_in_ready <= 1'b0;
                            r_error    <= 1'b1;
                        end else if (w_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_in_ready <= 1'b0;
                            r_core_rst <= 1'b0;
                            r_done     <= 1'b1;
`endif
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (r_remain == 16'd0) begin
                        // One idle cycle after the last write so done trails we by an edge
                        r_state    <= S_DONE;
                        r_core_rst <= 1'b0;
                        r_done     <= 1'b1;
                    end else if (w_accept) begin
                        r_bcnt <= r_bcnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor  <= r_xor ^ bus.in_data;
`endif
                        case (r_bcnt)
                            2'd0: r_word[7:0]   <= bus.in_data;
                            2'd1: r_word[15:8]  <= bus.in_data;
                            2'd2: r_word[23:16] <= bus.in_data;
                            default: begin
                                r_we     <= 1'b1;
                                r_wa     <= {r_widx, 2'b00};
                                r_wd     <= INS_W'({bus.in_data, r_word});
                                r_widx   <= r_widx + WIDX_W'(1);
                                r_remain <= r_remain - 16'd1;
                                if (r_remain == 16'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                    r_state    <= S_CHK;
`else
                                    r_in_ready <= 1'b0;
`endif
                                end
                            end
                        endcase
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_xor) begin
                            r_state    <= S_DONE;
                            r_core_rst <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_state <= S_ERR;
                            r_error <= 1'b1;
                        end
                    end
                end
`endif

                S_DONE, S_ERR: begin
                    if (bus.restart) begin
                        r_state    <= S_HDR0;
                        r_in_ready <= 1'b1;
                        r_core_rst <= 1'b1;
                        r_done     <= 1'b0;
                        r_error    <= 1'b0;
                        r_widx     <= '0;
                        r_bcnt     <= 2'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_xor      <= 8'd0;
`endif
                    end
                end

                default: begin
                    r_state <= S_HDR0;
                end
            endcase
        end
    end

    assign bus.in_ready = r_in_ready;
    assign bus.we       = r_we;
    assign bus.wa       = r_wa;
    assign bus.wd       = r_wd;
    assign bus.core_rst = r_core_rst;
    assign bus.done     = r_done;
    assign bus.error    = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader: directed vector table,
//               hand-written reset/DONE sequences and randomized loads.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

    localparam int INS_ADDRESS = 9;
    localparam int INS_W       = 32;
    localparam int DEPTH       = 2 ** (INS_ADDRESS - 2);

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [INS_ADDRESS-1:0] a;
        logic [31:0]            d;
    } wr_t;

    typedef struct {
        int                     n;
        logic [0:11][7:0]       b;
        int                     nwr;
        logic [31:0]            first_wd;
        logic [INS_ADDRESS-1:0] last_wa;
        logic [31:0]            last_wd;
        bit                     we_now;
        bit                     done_now;
        bit                     done;
        bit                     err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    imem_loader_if #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) bus ();

    imem_loader #(.INS_ADDRESS(INS_ADDRESS), .INS_W(INS_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   last_we_cyc = -1;
    int   done_cyc = -1;
    logic prev_done = 1'b0;
    wr_t  wr_q[$];
    wr_t  exp_q[$];
    bq_t  stim;
    vec_t tbl[$];
    bit   m_done, m_err;
    int   m_used;

    // Observe write strobes just after each active edge
    always @(posedge clk) begin
        #1;
        cyc++;
        if (bus.we === 1'b1) begin
            wr_q.push_back({bus.wa, bus.wd});
            last_we_cyc = cyc;
        end
        if (bus.done === 1'b1 && prev_done !== 1'b1) done_cyc = cyc;
        prev_done = bus.done;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_t wr_at(input int i);
        if (i >= 0 && i < wr_q.size()) return wr_q[i];
        return '1;
    endfunction

    // Reference: what a correct loader writes and concludes for stream 'stim'
    task automatic model();
        int         cnt;
        logic [7:0] x;
        exp_q.delete();
        m_done = 1'b0;
        m_err  = 1'b0;
        m_used = 2;
        cnt = int'(stim[1]) * 256 + int'(stim[0]);
        if (cnt > DEPTH) begin
            m_err = 1'b1;
            return;
        end
        x = 8'd0;
        for (int w = 0; w < cnt; w++) begin
            exp_q.push_back({INS_ADDRESS'(4 * w),
                             stim[2 + 4*w + 3], stim[2 + 4*w + 2],
                             stim[2 + 4*w + 1], stim[2 + 4*w]});
            for (int k = 0; k < 4; k++) x = x ^ stim[2 + 4*w + k];
        end
        m_used = 2 + 4 * cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
        m_used = m_used + 1;
        if (stim[m_used - 1] == x) m_done = 1'b1;
        else                       m_err  = 1'b1;
`else
        m_done = 1'b1;
`endif
    endtask

    task automatic gen(input int cnt, input bit bad_sum);
        logic [7:0] x;
        logic [7:0] b;
        x = 8'd0;
        stim.delete();
        stim.push_back(cnt[7:0]);
        stim.push_back(cnt[15:8]);
        if (cnt <= DEPTH) begin
            for (int i = 0; i < 4 * cnt; i++) begin
                b = 8'($urandom);
                stim.push_back(b);
                x = x ^ b;
            end
            if (bad_sum) x = ~x;
`ifdef IMEM_LOADER_CHECKSUM_EN
            stim.push_back(x);
`endif
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            bus.in_valid = 1'b0;
            bus.in_data  = 8'($urandom);
            @(negedge clk);
        end
    endtask

    // mode 0: valid held high, 1: valid every other cycle, 2: random gaps
    task automatic send(input int first, input int n, input int mode, output bit ok);
        ok = 1'b1;
        for (int i = first; i < first + n; i++) begin
            if (mode == 1 && i != first) idle(1);
            else if (mode == 2) idle(($urandom_range(2, 0) == 0) ? $urandom_range(3, 1) : 0);
            bus.in_data  = stim[i];
            bus.in_valid = 1'b1;
            for (int t = 0; bus.in_ready !== 1'b1; t++) begin
                if (t >= 20) begin
                    ok = 1'b0;
                    bus.in_valid = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_end(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            if (bus.done === 1'b1 || bus.error === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic do_restart(input string tag);
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check({tag, " restart in_ready"}, bus.in_ready, 1'b1);
        check({tag, " restart done"},     bus.done,     1'b0);
        check({tag, " restart error"},    bus.error,    1'b0);
        check({tag, " restart core_rst"}, bus.core_rst, 1'b1);
    endtask

    task automatic run_load(input int mode, input string tag);
        bit ok;
        model();
        wr_q.delete();
        last_we_cyc = -1;
        done_cyc    = -1;
        send(0, m_used, mode, ok);
        check({tag, " accept"}, ok, 1'b1);
        wait_end(ok);
        check({tag, " finish"},   ok, 1'b1);
        check({tag, " done"},     bus.done,     m_done);
        check({tag, " error"},    bus.error,    m_err);
        check({tag, " core_rst"}, bus.core_rst, !m_done);
        check({tag, " in_ready"}, bus.in_ready, 1'b0);
        check({tag, " nwrites"},  wr_q.size(),  exp_q.size());
        foreach (exp_q[i]) check({tag, " write"}, wr_at(i), exp_q[i]);
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (exp_q.size() > 0) check({tag, " done latency"}, done_cyc - last_we_cyc, 1);
`endif
    endtask

    initial begin
        bit ok;
        bus.in_data  = 8'd0;
        bus.in_valid = 1'b0;
        bus.restart  = 1'b0;
        reset        = 1'b1;
        repeat (2) @(negedge clk);
        check("reset in_ready", bus.in_ready, 1'b1);
        check("reset we",       bus.we,       1'b0);
        check("reset wa",       bus.wa,       '0);
        check("reset wd",       bus.wd,       '0);
        check("reset core_rst", bus.core_rst, 1'b1);
        check("reset done",     bus.done,     1'b0);
        check("reset error",    bus.error,    1'b0);
        reset = 1'b0;
        @(negedge clk);

        // ---------------- directed vector table ----------------
`ifdef IMEM_LOADER_CHECKSUM_EN
        tbl.push_back('{11, 96'h02_00_13_01_20_00_B3_05_A1_00_25_00, 2, 32'h00200113, 9'h004, 32'h00A105B3, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{7,  96'h01_00_13_01_20_00_32_00_00_00_00_00, 1, 32'h00200113, 9'h000, 32'h00200113, 1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{7,  96'h01_00_13_01_20_00_33_00_00_00_00_00, 1, 32'h00200113, 9'h000, 32'h00200113, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{3,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0,        9'h000, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0});
        tbl.push_back('{3,  96'h00_00_01_00_00_00_00_00_00_00_00_00, 0, 32'h0,        9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1});
`else
        tbl.push_back('{10, 96'h02_00_13_01_20_00_B3_05_A1_00_00_00, 2, 32'h00200113, 9'h004, 32'h00A105B3, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{6,  96'h01_00_EF_BE_AD_DE_00_00_00_00_00_00, 1, 32'hDEADBEEF, 9'h000, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{2,  96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0,        9'h000, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0});
`endif
        tbl.push_back('{2,  96'h81_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0,        9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{2,  96'h00_01_00_00_00_00_00_00_00_00_00_00, 0, 32'h0,        9'h000, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1});

        foreach (tbl[k]) begin
            stim.delete();
            for (int i = 0; i < tbl[k].n; i++) stim.push_back(tbl[k].b[i]);
            wr_q.delete();
            send(0, tbl[k].n, 0, ok);
            check($sformatf("vec%0d accept", k),   ok,          1'b1);
            check($sformatf("vec%0d we_now", k),   bus.we,      tbl[k].we_now);
            check($sformatf("vec%0d done_now", k), bus.done,    tbl[k].done_now);
            wait_end(ok);
            check($sformatf("vec%0d finish", k),   ok,          1'b1);
            check($sformatf("vec%0d done", k),     bus.done,    tbl[k].done);
            check($sformatf("vec%0d error", k),    bus.error,   tbl[k].err);
            check($sformatf("vec%0d core_rst", k), bus.core_rst, !tbl[k].done);
            check($sformatf("vec%0d in_ready", k), bus.in_ready, 1'b0);
            check($sformatf("vec%0d nwrites", k),  wr_q.size(), tbl[k].nwr);
            if (tbl[k].nwr > 0) begin
                check($sformatf("vec%0d first", k), wr_at(0), {INS_ADDRESS'(0), tbl[k].first_wd});
                check($sformatf("vec%0d last", k),  wr_at(tbl[k].nwr - 1), {tbl[k].last_wa, tbl[k].last_wd});
            end
            do_restart($sformatf("vec%0d", k));
        end

        // ---------------- full-depth load ----------------
        gen(DEPTH, 1'b0);
        run_load(0, "full");
        check("full last wa", wr_at(DEPTH - 1) >> 32, 64'h1FC);

        // bytes offered in DONE/ERR are not consumed
        bus.in_data  = 8'hA5;
        bus.in_valid = 1'b1;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check("hold nwrites", wr_q.size(), DEPTH);
        check("hold in_ready", bus.in_ready, 1'b0);
        check("hold state", {bus.done, bus.error}, {m_done, m_err});
        do_restart("full");

        // ---------------- reset in the middle of DATA ----------------
        gen(2, 1'b0);
        wr_q.delete();
        send(0, 8, 1, ok);
        check("midrst accept", ok, 1'b1);
        check("midrst pre wd", bus.wd, 32'({stim[5], stim[4], stim[3], stim[2]}));
        #2;
        reset = 1'b1;
        #1;
        check("midrst in_ready", bus.in_ready, 1'b1);
        check("midrst we",       bus.we,       1'b0);
        check("midrst wa",       bus.wa,       '0);
        check("midrst wd",       bus.wd,       '0);
        check("midrst core_rst", bus.core_rst, 1'b1);
        check("midrst done",     bus.done,     1'b0);
        check("midrst error",    bus.error,    1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        gen(3, 1'b0);
        run_load(1, "reload");
        do_restart("reload");

        // ---------------- randomized loads ----------------
        for (int r = 0; r < 24; r++) begin
            int cnt;
            case ($urandom_range(5, 0))
                0:       cnt = 0;
                1:       cnt = int'($urandom_range(3, 1));
                2:       cnt = int'($urandom_range(12, 4));
                3:       cnt = DEPTH;
                4:       cnt = DEPTH - 1;
                default: cnt = DEPTH + 1 + int'($urandom_range(65535 - DEPTH - 1, 0));
            endcase
            gen(cnt, $urandom_range(3, 0) == 0);
            run_load(int'($urandom_range(2, 0)), $sformatf("rnd%0d", r));
            do_restart($sformatf("rnd%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
